// File: rtl/adc_scan_serial_tx.sv
// Multi-channel ADC scan sequencer feeding a start/stop serial transmitter, MSB first.
// Define ADC_TX_PARITY_EN to add an even-parity bit between the last data bit and the stop bit.
module adc_scan_serial_tx #(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 8,
    parameter int CH_W      = 4,
    parameter int BIT_DELAY = 104
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              eoc,
    input  logic              dsr,
    input  logic [DATA_W-1:0] data_in,
    output logic              soc,
    output logic              load_dato,
    output logic              mux_en,
    output logic [CH_W-1:0]   canale,
    output logic              data_out,
    output logic              error,
    output logic              busy
);

`ifdef ADC_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = DATA_W + 2 + PAR_BITS;
    localparam int IDX_W      = $clog2(FRAME_BITS);
    localparam int CNT_W      = (BIT_DELAY > 0) ? $clog2(BIT_DELAY + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(BIT_DELAY);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_DATA_END = IDX_W'(DATA_W);
    localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(NUM_CH - 1);

    // state | meaning: MUX select channel, SETTLE mux settling, SOC start conversion,
    // WAIT wait for eoc low, LATCH ADC output enable, SEND hand-off/refusal, TXWAIT frame in flight
    localparam logic [2:0] S_MUX    = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_SOC    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_LATCH  = 3'd4;
    localparam logic [2:0] S_SEND   = 3'd5;
    localparam logic [2:0] S_TXWAIT = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   canale_q, canale_d;
    logic              error_q, error_d;
    logic              soc_q, soc_d;
    logic              load_q, load_d;
    logic              mux_en_q, mux_en_d;
    logic              capture, tx_start;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              tx_done_q, tx_done_d;
`ifdef ADC_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    always_comb begin
        state_d  = state_q;
        canale_d = canale_q;
        error_d  = error_q;
        capture  = 1'b0;
        tx_start = 1'b0;
        case (state_q)
            S_MUX:    state_d = S_SETTLE;
            S_SETTLE: state_d = S_SOC;
            S_SOC:    state_d = S_WAIT;
            S_WAIT:   if (!eoc) state_d = S_LATCH;
            S_LATCH: begin
                capture  = 1'b1;
                canale_d = (canale_q == CH_LAST) ? '0 : canale_q + CH_W'(1);
                state_d  = S_SEND;
            end
            S_SEND: begin
                if (dsr) begin
                    tx_start = 1'b1;
                    error_d  = 1'b0;
                    state_d  = S_TXWAIT;
                end else begin
                    error_d  = 1'b1;
                    state_d  = S_MUX;
                end
            end
            S_TXWAIT: if (tx_done_q) state_d = S_MUX;
            default:  state_d = S_MUX;
        endcase
        // Outputs follow the state being entered so they change on the same edge.
        soc_d    = (state_d == S_SOC) || (state_d == S_WAIT);
        load_d   = (state_d == S_LATCH);
        mux_en_d = (state_d == S_MUX) || (state_d == S_SETTLE) ||
                   (state_d == S_SOC) || (state_d == S_WAIT);
    end

    always_comb begin
        shift_d   = shift_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        tx_done_d = 1'b0;
`ifdef ADC_TX_PARITY_EN
        par_d     = par_q;
        if (capture) par_d = ^data_in;
`endif
        if (capture) shift_d = data_in;
        if (tx_start) begin
            idx_d  = '0;
            cnt_d  = '0;
            dout_d = 1'b0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    busy_d    = 1'b0;
                    dout_d    = 1'b1;
                    tx_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q < IDX_DATA_END) begin
                        dout_d  = shift_q[DATA_W-1];
                        shift_d = shift_q << 1;
                    end
`ifdef ADC_TX_PARITY_EN
                    else if (idx_q == IDX_DATA_END) dout_d = par_q;
`endif
                    else dout_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_MUX;
            canale_q  <= '0;
            error_q   <= 1'b0;
            soc_q     <= 1'b0;
            load_q    <= 1'b0;
            mux_en_q  <= 1'b0;
            shift_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            dout_q    <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
`ifdef ADC_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            canale_q  <= canale_d;
            error_q   <= error_d;
            soc_q     <= soc_d;
            load_q    <= load_d;
            mux_en_q  <= mux_en_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
`ifdef ADC_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign soc       = soc_q;
    assign load_dato = load_q;
    assign mux_en    = mux_en_q;
    assign canale    = canale_q;
    assign data_out  = dout_q;
    assign error     = error_q;
    assign busy      = busy_q;

endmodule

// File: doc/adc_scan_serial_tx.md
# adc_scan_serial_tx

Parametrised multi-channel ADC scan controller with an integrated UART-style serial transmitter. It sequences an external ADC through mux select, start-of-conversion and end-of-conversion handshakes, and latches each sample. It then serialises the sample MSB-first on `data_out`, gated by the remote `dsr`, and advances to the next channel. Channel count, sample width and bit period are generic, and an optional parity bit is available.

## Interface
- `DATA_W`, default 8: sample width and number of serial data bits.
- `NUM_CH`, default 8: number of channels scanned, range 2..2^CH_W.
- `CH_W`, default 4: width of `canale`.
- `BIT_DELAY`, default 104: each serial bit is held for BIT_DELAY+1 clock cycles. Minimum 0.

Ports (clock and reset first):
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `eoc`  in  1  ADC busy; a sample is ready when it is low.
- `dsr`  in  1  receiver ready, sampled when a frame starts.
- `data_in`  in  DATA_W  ADC sample.
- `soc`  out  1  start of conversion.
- `load_dato`  out  1  ADC output-enable strobe.
- `mux_en`  out  1  analog mux enable.
- `canale`  out  CH_W  channel being converted.
- `data_out`  out  1  serial line, idle high.
- `error`  out  1  sticky send-refused flag.
- `busy`  out  1  a frame is in flight.

## Operation
- All outputs are registered and update on the same edge as the state change.
- Reset values: `soc`=0, `load_dato`=0, `mux_en`=0, `canale`=0, `data_out`=1, `error`=0, `busy`=0. After reset the sampler is in S_MUX and the transmitter is in T_IDLE.
- Reset may assert at any time, including mid-frame. It aborts the frame immediately, and `data_out` returns to 1 asynchronously.

Sampler FSM:
- S_MUX: `mux_en`=1. After 1 cycle, go to S_SETTLE.
- S_SETTLE: 1 cycle, then go to S_SOC.
- S_SOC: `soc`=1, then go to S_WAIT.
- S_WAIT: hold `soc`=1 while `eoc`=1. When `eoc`=0 is sampled, go to S_LATCH.
- S_LATCH: `load_dato`=1 and `mux_en`=0. On exit, capture `data_in` into the shift register, then go to S_SEND.
- S_SEND: `soc`=0 and `load_dato`=0. `canale` becomes (`canale`+1) mod NUM_CH; it wraps from NUM_CH-1 to 0.
  - If `dsr`=1: start the transmitter, clear `error`, and go to S_TXWAIT.
  - If `dsr`=0: set `error`=1, drop the sample, and go to S_MUX.
- S_TXWAIT: wait for the one-cycle `tx_done` pulse from the transmitter, then go to S_MUX.

Transmitter:
- Frame format: start bit (0), DATA_W data bits MSB first, optional parity bit, stop bit (1).
- The bit counter counts 0..BIT_DELAY. The bit index advances when the counter equals BIT_DELAY.
- `busy`=1 from the first cycle of the start bit through the last cycle of the stop bit.
- `tx_done` is asserted internally in the cycle after the stop bit ends.
- `error` stays set until the next accepted send. Only a refused send (`dsr`=0 in S_SEND) sets it.

## Timing
- From S_MUX entry to the first possible `load_dato` is 4 cycles when `eoc` is already low.
- `load_dato` is a 1-cycle pulse.
- `data_out` drops to 0 on the edge leaving S_SEND.
- Frame length is (DATA_W+2[+1]) × (BIT_DELAY+1) cycles.
- S_MUX is re-entered on the cycle after `tx_done`.
- If `eoc` is stuck high, the sampler waits in S_WAIT indefinitely with `soc`=1; no timeout.
- `dsr` is not sampled after the frame has started, so dropping it mid-frame has no effect.
- The counter width is clog2(BIT_DELAY+1), minimum 1 bit. With BIT_DELAY=0, a new bit is sent every cycle.

## Configuration
- `ADC_TX_PARITY_EN` defined: an even-parity bit (XOR of the data bits) is inserted between the last data bit and the stop bit. The frame is DATA_W+3 bits.
- `ADC_TX_PARITY_EN` undefined: no parity bit. The frame is DATA_W+2 bits and no parity logic is present.

## Test plan
- Reset check: assert `reset` mid-run, including mid-frame. All outputs take their reset values (`data_out`=1, `canale`=0) without waiting for a clock edge. After release, `mux_en`=1 on the first edge.
- Single sample, no parity, BIT_DELAY=3: `eoc`=0, `dsr`=1, `data_in`=8'hA5. `data_out` sends 0,1,0,1,0,0,1,0,1,1 with each bit lasting 4 cycles. `busy` is high for 40 cycles and `canale` becomes 1.
- Channel wrap, NUM_CH=3: run 4 samples. `canale` sequence is 0,1,2,0,1.
- DSR refusal: `dsr`=0 in S_SEND. `error`=1, `data_out` stays 1, `busy`=0, and `canale` still advances. On the next sample with `dsr`=1, `error` clears in S_SEND.
- EOC stall: hold `eoc`=1 for 20 cycles. `soc` stays 1 and `load_dato` stays 0. `load_dato` pulses 1 cycle after `eoc` falls.
- Parity (macro defined): `data_in`=8'hA5 gives parity bit 0; `data_in`=8'h07 gives parity bit 1. The frame is 11 bits long.
